wb_mux_n: RTL and testbench

WB_MUX_N -- requirements
Module: wb_mux_n

---
 rtl/wb_pkg.sv | 23 ++
 rtl/wb_if.sv | 20 ++
 rtl/wb_addr_decoder.sv | 33 +++
 rtl/wb_mux_n.sv | 147 ++++++++++++++
 tb/tb_wb_mux_n.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and helpers for the wishbone slave mux
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    DRAIN   = 2'd2,
    ERR_RSP = 2'd3
  } wb_state_e;

  // Slave index width; the mux supports up to 16 ports.
  localparam int IDX_W = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_if.sv
// rtl/wb_if.sv - pipelined wishbone bus bundle
interface wb_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH-1:0]   dat_m;
  logic [SELECT_WIDTH-1:0] sel;
  logic                    stall;
  logic                    ack;
  logic                    err;
  logic [DATA_WIDTH-1:0]   dat_s;

  modport master (output cyc, stb, we, adr, dat_m, sel, input stall, ack, err, dat_s);
  modport slave  (input cyc, stb, we, adr, dat_m, sel, output stall, ack, err, dat_s);
endinterface

// File: rtl/wb_addr_decoder.sv
// rtl/wb_addr_decoder.sv - masked base-address decode, lowest index wins
module wb_addr_decoder
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SLAVES = 5,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_ADDRESSES  = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_ADDR_MASKS = '0
) (
  input  logic [ADDR_WIDTH-1:0] adr,
  output logic [NUM_SLAVES-1:0] match,
  output logic [IDX_W-1:0]      idx,
  output logic                  unmapped
);
  logic [NUM_SLAVES-1:0] raw;

  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_cmp
    localparam logic [ADDR_WIDTH-1:0] BASE = SLAVE_ADDRESSES[i*ADDR_WIDTH +: ADDR_WIDTH];
    localparam logic [ADDR_WIDTH-1:0] MASK = SLAVE_ADDR_MASKS[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign raw[i] = (adr & MASK) == (BASE & MASK);
  end

  // Isolating the lowest set bit gives the priority one-hot directly.
  assign match    = raw & (~raw + NUM_SLAVES'(1));
  assign unmapped = ~|raw;

  always_comb begin
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (raw[i]) idx = IDX_W'(i);
    end
  end
endmodule

// File: rtl/wb_mux_n.sv
// rtl/wb_mux_n.sv - one wishbone master to N pipelined slaves with outstanding tracking
module wb_mux_n
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int SELECT_WIDTH    = DATA_WIDTH / 8,
  parameter int NUM_SLAVES      = 5,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_ADDRESSES  = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_ADDR_MASKS = '0,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input logic  clk,
  input logic  rst_n,
  wb_if.slave  wbm,
  wb_if.master wbs [NUM_SLAVES]
);
  localparam int CNT_W = clog2(MAX_OUTSTANDING + 1);
  localparam int WDG_W = clog2(TIMEOUT_CYCLES + 1);

  wb_state_e         state, state_nxt;
  logic [IDX_W-1:0]  sel_q, sel_nxt, hit_idx;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [WDG_W-1:0]  wdog, wdog_nxt;

  logic [NUM_SLAVES-1:0] s_stall, s_ack, s_err, hit_vec, sel_vec, tgt;
  logic [DATA_WIDTH-1:0] s_dat [NUM_SLAVES];
  logic [DATA_WIDTH-1:0] dat_mux;
  logic [SELECT_WIDTH-1:0] sel_b;

  logic unmapped, req, cnt_nz, full, idle_like, same, rsp, timeout, abort;
  logic cyc_on, stb_on, stall, acc;

  wb_addr_decoder #(
    .ADDR_WIDTH       (ADDR_WIDTH),
    .NUM_SLAVES       (NUM_SLAVES),
    .SLAVE_ADDRESSES  (SLAVE_ADDRESSES),
    .SLAVE_ADDR_MASKS (SLAVE_ADDR_MASKS)
  ) u_dec (
    .adr      (wbm.adr),
    .match    (hit_vec),
    .idx      (hit_idx),
    .unmapped (unmapped)
  );

  assign req       = wbm.cyc & wbm.stb;
  assign cnt_nz    = (count != '0);
  assign full      = (count == CNT_W'(MAX_OUTSTANDING));
  // With nothing outstanding, DRAIN may pick up the pending request like IDLE.
  assign idle_like = (state == IDLE) || (state == ERR_RSP) || (state == DRAIN && !cnt_nz);
  assign same      = !unmapped && (hit_idx == sel_q);
  assign sel_vec   = NUM_SLAVES'(1) << sel_q;
  assign tgt       = idle_like ? hit_vec : sel_vec;
  assign rsp       = wbm.cyc & cnt_nz & |((s_ack | s_err) & tgt);
  assign timeout   = cnt_nz && (wdog == WDG_W'(TIMEOUT_CYCLES - 1)) && !rsp;
  assign abort     = timeout || !wbm.cyc;

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    count_nxt = count;
    wdog_nxt  = wdog;
    cyc_on    = 1'b0;
    stb_on    = 1'b0;
    stall     = 1'b0;
    acc       = 1'b0;
    if (idle_like) begin
      cyc_on = req && !unmapped;
      stb_on = req && !unmapped;
      stall  = req && !unmapped && |(s_stall & tgt);
      if (req) begin
        state_nxt = unmapped ? ERR_RSP : ACTIVE;
        if (!unmapped) sel_nxt = hit_idx;
      end else begin
        state_nxt = IDLE;
      end
    end else if (state == ACTIVE) begin
      cyc_on = 1'b1;
      if (req && !same) begin
        stall     = 1'b1;
        state_nxt = DRAIN;
      end else begin
        stb_on = req && !full;
        stall  = full || |(s_stall & tgt);
      end
    end else begin
      cyc_on = 1'b1;
      stall  = 1'b1;
    end
    if (abort) begin
      cyc_on    = 1'b0;
      stb_on    = 1'b0;
      stall     = timeout;
      state_nxt = IDLE;
    end
    acc = stb_on && !stall;
    if (acc && !rsp) count_nxt = count + CNT_W'(1);
    else if (!acc && rsp) count_nxt = count - CNT_W'(1);
    wdog_nxt = (rsp || !cnt_nz) ? '0 : wdog + WDG_W'(1);
    if (abort) begin
      count_nxt = '0;
      wdog_nxt  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel_q <= '0;
      count <= '0;
      wdog  <= '0;
    end else begin
      state <= state_nxt;
      sel_q <= sel_nxt;
      count <= count_nxt;
      wdog  <= wdog_nxt;
    end
  end

  always_comb begin
    dat_mux = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      dat_mux = dat_mux | (s_dat[i] & {DATA_WIDTH{tgt[i]}});
    end
  end

  // Responses are qualified by rst_n and count so aborted transfers stay silent.
  assign wbm.stall = rst_n & stall;
  assign wbm.ack   = rst_n & wbm.cyc & cnt_nz & |(s_ack & tgt);
  assign wbm.err   = rst_n & wbm.cyc & ((state == ERR_RSP) | timeout | (cnt_nz & |(s_err & tgt)));
  assign wbm.dat_s = dat_mux;
  assign sel_b     = wbm.sel;

  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_port
    assign wbs[i].cyc   = rst_n & cyc_on & tgt[i];
    assign wbs[i].stb   = rst_n & stb_on & tgt[i];
    assign wbs[i].we    = wbm.we;
    assign wbs[i].adr   = wbm.adr;
    assign wbs[i].dat_m = wbm.dat_m;
    assign wbs[i].sel   = sel_b;
    assign s_stall[i]   = wbs[i].stall;
    assign s_ack[i]     = wbs[i].ack;
    assign s_err[i]     = wbs[i].err;
    assign s_dat[i]     = wbs[i].dat_s;
  end
endmodule

// File: tb/tb_wb_mux_n.sv
// tb/tb_wb_mux_n.sv - directed bench for wb_mux_n
module tb_wb_mux_n;
  localparam int NS = 5;
  localparam logic [NS*32-1:0] ADDRS = {32'h1000_0000, 32'h3000_0000, 32'h2000_0000,
                                        32'h1000_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] MASKS = {32'hFF00_0000, 32'hF000_0000, 32'hF000_0000,
                                        32'hF000_0000, 32'hF000_0000};

  logic clk, rst_n;
  logic m_cyc, m_stb, m_we;
  logic [31:0] m_adr, m_dat;
  logic [NS-1:0] s_stall, s_ack, s_err, obs_cyc, obs_stb;
  logic [31:0] s_dat [NS];
  int checks, errors, acc_n, ack_n, waited;

  wb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) wbm_if ();
  wb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) wbs_if [NS] ();

  assign wbm_if.cyc   = m_cyc;
  assign wbm_if.stb   = m_stb;
  assign wbm_if.we    = m_we;
  assign wbm_if.adr   = m_adr;
  assign wbm_if.dat_m = m_dat;
  assign wbm_if.sel   = 4'hF;

  for (genvar g = 0; g < NS; g++) begin : g_slv
    assign wbs_if[g].stall = s_stall[g];
    assign wbs_if[g].ack   = s_ack[g];
    assign wbs_if[g].err   = s_err[g];
    assign wbs_if[g].dat_s = s_dat[g];
    assign obs_cyc[g]      = wbs_if[g].cyc;
    assign obs_stb[g]      = wbs_if[g].stb;
  end

  wb_mux_n #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_SLAVES(NS),
    .SLAVE_ADDRESSES(ADDRS), .SLAVE_ADDR_MASKS(MASKS),
    .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wbm(wbm_if), .wbs(wbs_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic w);
    m_adr = a; m_we = w; m_stb = 1'b1; waited = 0;
    @(negedge clk);
    while (wbm_if.stall && waited < 20) begin
      tick();
      @(negedge clk);
      waited++;
    end
    tick();
    m_stb = 1'b0;
    chk("issue_accepted", waited < 20, 1);
  endtask

  initial begin
    checks = 0; errors = 0;
    for (int i = 0; i < NS; i++) s_dat[i] = 32'hA5A5_0000 + i;
    rst_n = 1'b0; m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0;
    m_adr = 32'h2000_0000; m_dat = 32'hDEAD_BEEF;
    s_stall = '1; s_ack = '1; s_err = '0;

    // reset values with a live request and responding slaves
    @(negedge clk);
    chk("rst_stall", wbm_if.stall, 0);
    chk("rst_ack", wbm_if.ack, 0);
    chk("rst_err", wbm_if.err, 0);
    chk("rst_cyc", obs_cyc, 0);
    chk("rst_stb", obs_stb, 0);
    m_cyc = 1'b0; m_stb = 1'b0; s_stall = '0; s_ack = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // six back-to-back reads to slave 2, acks held off
    m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h2000_0010; acc_n = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) chk("first_stb_zero_latency", obs_stb, 5'b00100);
      if (k == 4) chk("full_no_stb", obs_stb, 0);
      chk("outstanding_stall", wbm_if.stall, (k >= 4));
      if (!wbm_if.stall) acc_n++;
      tick();
    end
    chk("accepted_count", acc_n, 4);
    m_stb = 1'b0; s_ack[2] = 1'b1; ack_n = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) chk("ack_data", wbm_if.dat_s, 32'hA5A5_0002);
      if (wbm_if.ack) ack_n++;
      tick();
    end
    s_ack[2] = 1'b0;
    chk("ack_count", ack_n, 4);
    @(negedge clk);
    chk("stall_after_drain", wbm_if.stall, 0);
    tick();

    // write to slave 0 pending, then read to slave 3
    issue(32'h0000_0100, 1'b1);
    m_adr = 32'h3000_0000; m_we = 1'b0; m_stb = 1'b1;
    @(negedge clk);
    chk("switch_stall", wbm_if.stall, 1);
    chk("switch_no_stb", obs_stb, 0);
    chk("switch_cyc_old", obs_cyc, 5'b00001);
    tick();
    @(negedge clk);
    chk("drain_stall", wbm_if.stall, 1);
    tick();
    s_ack[0] = 1'b1;
    @(negedge clk);
    chk("drain_ack", wbm_if.ack, 1);
    chk("drain_ack_stall", wbm_if.stall, 1);
    tick();
    s_ack[0] = 1'b0;
    @(negedge clk);
    chk("reselect_stb", obs_stb, 5'b01000);
    chk("reselect_stall", wbm_if.stall, 0);
    tick();
    m_stb = 1'b0; s_ack[3] = 1'b1;
    @(negedge clk);
    chk("slave3_ack", wbm_if.ack, 1);
    tick();
    s_ack[3] = 1'b0;

    // unmapped address
    m_adr = 32'hFFFF_0000; m_stb = 1'b1;
    @(negedge clk);
    chk("unmapped_stall_active", wbm_if.stall, 1);
    tick();
    @(negedge clk);
    chk("unmapped_accept", wbm_if.stall, 0);
    chk("unmapped_no_stb", obs_stb, 0);
    chk("unmapped_err_early", wbm_if.err, 0);
    tick();
    m_stb = 1'b0;
    @(negedge clk);
    chk("unmapped_err", wbm_if.err, 1);
    chk("unmapped_no_stb2", obs_stb, 0);
    tick();
    @(negedge clk);
    chk("unmapped_err_once", wbm_if.err, 0);

    // overlapping masks: slave 1 beats slave 4
    m_adr = 32'h1000_0040; m_stb = 1'b1;
    @(negedge clk);
    chk("overlap_stb", obs_stb, 5'b00010);
    tick();
    m_stb = 1'b0; s_ack[1] = 1'b1; s_dat[1] = 32'h1111_0001;
    @(negedge clk);
    chk("overlap_ack", wbm_if.ack, 1);
    chk("overlap_dat", wbm_if.dat_s, 32'h1111_0001);
    tick();
    s_ack[1] = 1'b0;

    // watchdog: slave 2 never acks
    issue(32'h2000_0000, 1'b0);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk("wdog_quiet", {wbm_if.err, obs_cyc}, 6'b000100);
      tick();
    end
    @(negedge clk);
    chk("wdog_err", wbm_if.err, 1);
    chk("wdog_cyc_drop", obs_cyc, 0);
    tick();
    @(negedge clk);
    chk("wdog_err_once", wbm_if.err, 0);
    m_adr = 32'h2000_0000; m_stb = 1'b1;
    #1;
    chk("post_wdog_stb", obs_stb, 5'b00100);
    chk("post_wdog_stall", wbm_if.stall, 0);
    tick();
    m_stb = 1'b0; s_ack[2] = 1'b1;
    @(negedge clk);
    chk("post_wdog_ack", wbm_if.ack, 1);
    tick();
    s_ack[2] = 1'b0;

    // master drops cyc with one outstanding
    issue(32'h2000_0000, 1'b0);
    m_cyc = 1'b0;
    @(negedge clk);
    chk("cycdrop_cyc", obs_cyc, 0);
    tick();
    m_cyc = 1'b1; s_ack[2] = 1'b1;
    @(negedge clk);
    chk("late_ack_blocked", wbm_if.ack, 0);
    tick();
    s_ack[2] = 1'b0;

    // reset with three outstanding
    m_adr = 32'h2000_0000; m_stb = 1'b1; acc_n = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (!wbm_if.stall) acc_n++;
      tick();
    end
    chk("three_accepted", acc_n, 3);
    m_stb = 1'b0; s_stall[2] = 1'b1;
    #1;
    chk("pre_rst_stall", wbm_if.stall, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_stall", wbm_if.stall, 0);
    chk("midrst_cyc", obs_cyc, 0);
    s_ack[2] = 1'b1;
    #1;
    chk("midrst_ack", wbm_if.ack, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postrst_ack", wbm_if.ack, 0);
    tick();
    @(negedge clk);
    chk("postrst_ack2", wbm_if.ack, 0);
    chk("postrst_cyc", obs_cyc, 0);
    s_ack[2] = 1'b0; s_stall[2] = 1'b0;
    m_stb = 1'b1;
    #1;
    chk("resume_stb", obs_stb, 5'b00100);
    tick();
    m_stb = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end
endmodule
